// File: rtl/sram_stream_ctrl.sv
// Byte-stream front end for a bank of 512x8 SRAM macros: pointer-based loads,
// single reads and credit-limited dump reads feeding a small output FIFO.
module sram_stream_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int OUT_DEPTH = 4,
    parameter int ADDR_W    = 9 + $clog2(NUM_BANKS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_mode,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [ADDR_W-1:0]      ptr,
    output logic                   ptr_wrapped,
    output logic                   busy,
    output logic [NUM_BANKS-1:0]   sram_cen,
    output logic [NUM_BANKS-1:0]   sram_gwen,
    output logic [7:0]             sram_wen,
    output logic [8:0]             sram_a,
    output logic [7:0]             sram_d,
    input  logic [8*NUM_BANKS-1:0] sram_q
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; ready never depends on valid, and valid/data hold until the transfer.

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HI_W   = ADDR_W - 8;

    localparam logic [2:0] M_LOAD = 3'b000;
    localparam logic [2:0] M_LO   = 3'b001;
    localparam logic [2:0] M_HI   = 3'b010;
    localparam logic [2:0] M_READ = 3'b011;
    localparam logic [2:0] M_DUMP = 3'b100;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(OUT_DEPTH);

    typedef enum logic {S_IDLE, S_DUMP} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic                   wrapped_q, wrapped_d;
    logic [7:0]             beats_q, beats_d;
    logic [NUM_BANKS-1:0]   cen_q, cen_d;
    logic [NUM_BANKS-1:0]   gwen_q, gwen_d;
    logic [7:0]             wen_q, wen_d;
    logic [8:0]             a_q, a_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   rd1_q, rd1_d;
    logic [BANK_W-1:0]      bank1_q, bank1_d;
    logic                   rd2_q, rd2_d;
    logic [BANK_W-1:0]      bank2_q, bank2_d;
    logic [7:0]             mem_q [OUT_DEPTH];
    logic [7:0]             mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [BANK_W-1:0]      bank;
    logic [CNT_W:0]         occ;
    logic                   credit;
    logic                   accept;
    logic                   do_read;
    logic                   step;
    logic                   push;
    logic                   pop;
    logic [7:0]             push_data;

    if (NUM_BANKS > 1) begin : g_bank
        assign bank = ptr_q[ADDR_W-1:9];
    end else begin : g_bank1
        assign bank = '0;
    end

    // Occupancy counts reads still in the macro pipeline so the FIFO cannot overflow.
    assign occ       = {1'b0, cnt_q} + (CNT_W + 1)'(rd1_q) + (CNT_W + 1)'(rd2_q);
    assign credit    = occ < DEPTH_C;
    assign in_ready  = (state_q == S_IDLE) && credit;
    assign accept    = in_valid && in_ready;
    assign out_valid = cnt_q != '0;
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = rd2_q;
    assign pop       = out_valid && out_ready;
    assign push_data = sram_q[8*int'(bank2_q) +: 8];

    assign ptr         = ptr_q;
    assign ptr_wrapped = wrapped_q;
    assign busy        = state_q == S_DUMP;
    assign sram_cen    = cen_q;
    assign sram_gwen   = gwen_q;
    assign sram_wen    = wen_q;
    assign sram_a      = a_q;
    assign sram_d      = wdata_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        beats_d   = beats_q;
        cen_d     = '1;
        gwen_d    = '1;
        wen_d     = 8'hFF;
        a_d       = a_q;
        wdata_d   = wdata_q;
        rd1_d     = 1'b0;
        bank1_d   = bank1_q;
        do_read   = 1'b0;
        step      = 1'b0;

        if (state_q == S_IDLE) begin
            if (accept) begin
                case (in_mode)
                    M_LOAD: begin
                        cen_d[bank]  = 1'b0;
                        gwen_d[bank] = 1'b0;
                        wen_d        = 8'h00;
                        a_d          = ptr_q[8:0];
                        wdata_d      = in_data;
                        step         = 1'b1;
                    end
                    M_LO: begin
                        ptr_d[7:0] = in_data;
                        wrapped_d  = 1'b0;
                    end
                    M_HI: begin
                        ptr_d[ADDR_W-1:8] = in_data[HI_W-1:0];
                        wrapped_d         = 1'b0;
                    end
                    M_READ: do_read = 1'b1;
                    M_DUMP: begin
                        state_d = S_DUMP;
                        beats_d = in_data;
                    end
                    default: ;
                endcase
            end
        end else if (credit) begin
            do_read = 1'b1;
            if (beats_q == 8'd0) begin
                state_d = S_IDLE;
            end else begin
                beats_d = beats_q - 8'd1;
            end
        end

        if (do_read) begin
            cen_d[bank] = 1'b0;
            a_d         = ptr_q[8:0];
            rd1_d       = 1'b1;
            bank1_d     = bank;
            step        = 1'b1;
        end

        if (step) begin
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == '1) begin
                wrapped_d = 1'b1;
            end
        end
    end

    // Read pipeline: stage 1 = pins driven, stage 2 = macro Q valid, then FIFO push.
    always_comb begin
        rd2_d    = rd1_q;
        bank2_d  = bank1_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            wrapped_q <= 1'b0;
            beats_q   <= '0;
            cen_q     <= '1;
            gwen_q    <= '1;
            wen_q     <= 8'hFF;
            a_q       <= '0;
            wdata_q   <= '0;
            rd1_q     <= 1'b0;
            bank1_q   <= '0;
            rd2_q     <= 1'b0;
            bank2_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            beats_q   <= beats_d;
            cen_q     <= cen_d;
            gwen_q    <= gwen_d;
            wen_q     <= wen_d;
            a_q       <= a_d;
            wdata_q   <= wdata_d;
            rd1_q     <= rd1_d;
            bank1_q   <= bank1_d;
            rd2_q     <= rd2_d;
            bank2_q   <= bank2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl: command table with pin/pointer checks,
// plus dump, credit-stall and asynchronous-reset sequences against a macro model.
module tb_sram_stream_ctrl;

    localparam int NB    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    localparam logic [2:0] M_LOAD = 3'b000;
    localparam logic [2:0] M_LO   = 3'b001;
    localparam logic [2:0] M_HI   = 3'b010;
    localparam logic [2:0] M_READ = 3'b011;
    localparam logic [2:0] M_DUMP = 3'b100;
    localparam logic [2:0] M_NOP  = 3'b111;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_mode;
    logic [7:0]      in_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [AW-1:0]   ptr;
    logic            ptr_wrapped;
    logic            busy;
    logic [NB-1:0]   sram_cen;
    logic [NB-1:0]   sram_gwen;
    logic [7:0]      sram_wen;
    logic [8:0]      sram_a;
    logic [7:0]      sram_d;
    logic [8*NB-1:0] sram_q;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    logic [7:0] mem [NB][512];
    logic [7:0] q_r [NB];

    typedef struct packed {
        logic [2:0]    mode;
        logic [7:0]    data;
        logic [AW-1:0] e_ptr;
        logic          e_wr;
        logic [NB-1:0] e_cen;
        logic [NB-1:0] e_gwen;
        logic [7:0]    e_wen;
        logic [8:0]    e_a;
        logic [7:0]    e_d;
        logic          rd;
        logic [7:0]    e_byte;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    sram_stream_ctrl #(.NUM_BANKS(NB), .OUT_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ptr         (ptr),
        .ptr_wrapped (ptr_wrapped),
        .busy        (busy),
        .sram_cen    (sram_cen),
        .sram_gwen   (sram_gwen),
        .sram_wen    (sram_wen),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- macro model ----------------
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!sram_cen[b]) begin
                if (!sram_gwen[b]) begin
                    mem[b][sram_a] <= (mem[b][sram_a] & sram_wen) | (sram_d & ~sram_wen);
                end else begin
                    q_r[b] <= mem[b][sram_a];
                end
            end
        end
    end

    always_comb begin
        sram_q = '0;
        for (int b = 0; b < NB; b++) begin
            sram_q[8*b +: 8] = q_r[b];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard: every accepted output byte must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] m, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now(name);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,    1);
        check({tag, "_out_valid"}, out_valid,   0);
        check({tag, "_out_data"},  out_data,    0);
        check({tag, "_ptr"},       ptr,         0);
        check({tag, "_wrapped"},   ptr_wrapped, 0);
        check({tag, "_busy"},      busy,        0);
        check({tag, "_cen"},       sram_cen,    2'b11);
        check({tag, "_gwen"},      sram_gwen,   2'b11);
        check({tag, "_wen"},       sram_wen,    8'hFF);
        check({tag, "_a"},         sram_a,      0);
        check({tag, "_d"},         sram_d,      0);
    endtask

    function automatic logic [7:0] img(input int a);
        if (a < 16) return 8'(a);
        if (a == 16) return 8'hA5;
        if (a == 17) return 8'h5A;
        return 8'h00;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        fail_now("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int busy_cycles;
        logic seen_idle;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 3'b000;
        in_data   = 8'h00;
        out_ready = 1'b1;
        for (int b = 0; b < NB; b++) begin
            q_r[b] = 8'h00;
            for (int i = 0; i < 512; i++) mem[b][i] = 8'h00;
        end

        //            mode    data   ptr      wr    cen    gwen   wen    a        d      rd    byte
        tbl[0]  = '{M_HI,   8'h00, 10'h000, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{M_LO,   8'h10, 10'h010, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{M_LOAD, 8'hA5, 10'h011, 1'b0, 2'b10, 2'b10, 8'h00, 9'h010, 8'hA5, 1'b0, 8'h00};
        tbl[3]  = '{M_LOAD, 8'h5A, 10'h012, 1'b0, 2'b10, 2'b10, 8'h00, 9'h011, 8'h5A, 1'b0, 8'h00};
        tbl[4]  = '{M_LO,   8'h10, 10'h010, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h011, 8'h5A, 1'b0, 8'h00};
        tbl[5]  = '{M_READ, 8'h00, 10'h011, 1'b0, 2'b10, 2'b11, 8'hFF, 9'h010, 8'h5A, 1'b1, 8'hA5};
        tbl[6]  = '{M_READ, 8'h00, 10'h012, 1'b0, 2'b10, 2'b11, 8'hFF, 9'h011, 8'h5A, 1'b1, 8'h5A};
        tbl[7]  = '{M_HI,   8'h01, 10'h112, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h011, 8'h5A, 1'b0, 8'h00};
        tbl[8]  = '{M_LO,   8'hFF, 10'h1FF, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h011, 8'h5A, 1'b0, 8'h00};
        tbl[9]  = '{M_LOAD, 8'h11, 10'h200, 1'b0, 2'b10, 2'b10, 8'h00, 9'h1FF, 8'h11, 1'b0, 8'h00};
        tbl[10] = '{M_LOAD, 8'h22, 10'h201, 1'b0, 2'b01, 2'b01, 8'h00, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[11] = '{M_HI,   8'h01, 10'h101, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[12] = '{M_LO,   8'hFF, 10'h1FF, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[13] = '{M_READ, 8'h00, 10'h200, 1'b0, 2'b10, 2'b11, 8'hFF, 9'h1FF, 8'h22, 1'b1, 8'h11};
        tbl[14] = '{M_READ, 8'h00, 10'h201, 1'b0, 2'b01, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b1, 8'h22};
        tbl[15] = '{M_NOP,  8'h5C, 10'h201, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[16] = '{M_HI,   8'hFF, 10'h301, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[17] = '{M_LO,   8'hFF, 10'h3FF, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h22, 1'b0, 8'h00};
        tbl[18] = '{M_LOAD, 8'h33, 10'h000, 1'b1, 2'b01, 2'b01, 8'h00, 9'h1FF, 8'h33, 1'b0, 8'h00};
        tbl[19] = '{M_READ, 8'h00, 10'h001, 1'b1, 2'b10, 2'b11, 8'hFF, 9'h000, 8'h33, 1'b1, 8'h00};
        tbl[20] = '{M_LO,   8'h00, 10'h000, 1'b0, 2'b11, 2'b11, 8'hFF, 9'h000, 8'h33, 1'b0, 8'h00};

        // reset
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // command table: load/read, bank crossing, NOP, wrap
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rd) exp_q.push_back(tbl[i].e_byte);
            send_cmd(tbl[i].mode, tbl[i].data);
            check($sformatf("v%0d_ptr", i),  ptr,         tbl[i].e_ptr);
            check($sformatf("v%0d_wrap", i), ptr_wrapped, tbl[i].e_wr);
            check($sformatf("v%0d_cen", i),  sram_cen,    tbl[i].e_cen);
            check($sformatf("v%0d_gwen", i), sram_gwen,   tbl[i].e_gwen);
            check($sformatf("v%0d_wen", i),  sram_wen,    tbl[i].e_wen);
            check($sformatf("v%0d_a", i),    sram_a,      tbl[i].e_a);
            check($sformatf("v%0d_d", i),    sram_d,      tbl[i].e_d);
        end
        wait_drain("table_drain");
        check("macro_b0_r511", mem[0][511], 8'h11);
        check("macro_b1_r0",   mem[1][0],   8'h22);
        check("macro_b1_r511", mem[1][511], 8'h33);
        check("idle_cen",      sram_cen,    2'b11);

        // dump with out_ready toggling
        for (int i = 0; i < 16; i++) send_cmd(M_LOAD, 8'(i));
        send_cmd(M_LO, 8'h00);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        send_cmd(M_DUMP, 8'h0F);
        check("dump_busy_start",  busy,     1);
        check("dump_ready_start", in_ready, 0);
        busy_cycles = 0;
        seen_idle   = 1'b0;
        for (int c = 0; c < 400 && (exp_q.size() != 0 || busy); c++) begin
            out_ready = (c % 2 == 0);
            if (busy) begin
                busy_cycles++;
                check("dump_busy_once", seen_idle, 0);
                check("dump_in_ready",  in_ready,  0);
            end else begin
                seen_idle = 1'b1;
            end
            tick();
        end
        out_ready = 1'b1;
        check("dump_all_bytes",  exp_q.size(), 0);
        check("dump_busy_len",   busy_cycles >= 16, 1);
        check("dump_busy_end",   busy, 0);
        check("dump_ptr",        ptr,  10'h010);
        repeat (4) tick();
        check("dump_no_extra",   out_valid, 0);

        // credit stall
        out_ready = 1'b0;
        send_cmd(M_LO, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'(i));
            send_cmd(M_READ, 8'h00);
        end
        check("stall_ready_low", in_ready, 0);
        repeat (3) tick();
        check("stall_ready_hold", in_ready,  0);
        check("stall_valid",      out_valid, 1);
        check("stall_head",       out_data,  8'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_ready_back", in_ready, 1);
        check("stall_next_head",  out_data, 8'h01);
        out_ready = 1'b1;
        wait_drain("stall_drain");

        // asynchronous reset in the middle of a long dump
        send_cmd(M_LO, 8'h00);
        for (int a = 0; a < 256; a++) exp_q.push_back(img(a));
        send_cmd(M_DUMP, 8'hFF);
        repeat (20) tick();
        check("mid_dump_busy", busy, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_access", sram_cen, 2'b11);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        send_cmd(M_DUMP, 8'h03);
        wait_drain("post_rst_drain");
        check("post_rst_ptr", ptr, 10'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
